// File: rtl/fft_sample_buffer_pkg.sv
// Shared types and helpers for the FFT sample buffer.
// Provides the buffer FSM encoding, minimum FFT size and bit reversal.
package fft_buffer_pkg;

  typedef enum logic [1:0] {
    BUF_LOAD,
    BUF_FEED,
    BUF_COLLECT,
    BUF_DONE
  } buf_fsm_e;

  localparam int MIN_LOG2 = 1;
  localparam int REV_W    = 16;

  // Reverse the low nbits of value; upper bits of the result are zero.
  function automatic logic [REV_W-1:0] bit_reverse(
    input logic [REV_W-1:0] value,
    input logic [4:0]       nbits
  );
    logic [REV_W-1:0] rev;
    for (int i = 0; i < REV_W; i++) begin
      rev[i] = value[REV_W-1-i];
    end
    return rev >> (5'(REV_W) - nbits);
  endfunction

endpackage

// File: rtl/fft_sample_buffer_if.sv
// Sample and result streams between the buffer and the FFT core.
// master: buffer side (drives samples, accepts results); slave: FFT core.
interface fft_sample_buffer_if;
  logic [15:0] fft_data;
  logic        fft_valid;
  logic        fft_last;
  logic        fft_ready;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_last;
  logic        res_ready;

  modport master (
    output fft_data, fft_valid, fft_last, res_ready,
    input  fft_ready, res_data, res_valid, res_last
  );

  modport slave (
    input  fft_data, fft_valid, fft_last, res_ready,
    output fft_ready, res_data, res_valid, res_last
  );
endinterface

// File: rtl/fft_sample_ram.sv
// Simple dual-port synchronous RAM, one write and one read port.
// Ports: we/waddr/wdata write; re/raddr read, rdata registered, holds when re low.
module fft_sample_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [1<<AW];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Contents are never cleared; only the output register resets.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_sample_buffer.sv
// Buffers bridge samples, streams them bit-reversed to the FFT core,
// then collects results for bridge reads. Bridge ports plain; FFT side in fft_if.
module fft_sample_buffer
  import fft_buffer_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int MAX_LOG2 = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_SAMPLE,
  input  logic [ADDR_W-1:0] i_SAMPLE_INDEX,
  input  logic              i_WRITE,
  input  logic              i_READ,
  input  logic              i_DATA_LOADED,
  input  logic [3:0]        i_N_LOG2,
  output logic [31:0]       o_DATA,
  output logic              o_CALC_END,
  output logic [ADDR_W-1:0] o_SAMPLES_NUMBER,
  fft_sample_buffer_if.master fft_if
);

  localparam int CW = ADDR_W + 1;

  buf_fsm_e          state_q, state_d;
  logic [3:0]        log2_q, log2_d;
  logic [CW-1:0]     feed_cnt_q, feed_cnt_d;
  logic [CW-1:0]     res_cnt_q, res_cnt_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              res_ready_q, res_ready_d;
  logic              calc_end_q, calc_end_d;
  logic [ADDR_W-1:0] snum_q, snum_d;

  logic              in_we;
  logic              feed_re;
  logic              res_we;
  logic [3:0]        log2_clamp;
  logic [CW-1:0]     n_frame;
  logic [ADDR_W-1:0] feed_addr;
  logic              feed_more;

  always_comb begin
    log2_clamp = i_N_LOG2;
    if (i_N_LOG2 < 4'(MIN_LOG2)) log2_clamp = 4'(MIN_LOG2);
    else if (i_N_LOG2 > 4'(MAX_LOG2)) log2_clamp = 4'(MAX_LOG2);
  end

  assign n_frame   = CW'(1) << log2_q;
  assign feed_more = feed_cnt_q < n_frame;
  assign feed_addr = ADDR_W'(bit_reverse(REV_W'(feed_cnt_q), {1'b0, log2_q}));

  always_comb begin
    state_d     = state_q;
    log2_d      = log2_q;
    feed_cnt_d  = feed_cnt_q;
    res_cnt_d   = res_cnt_q;
    valid_d     = valid_q;
    last_d      = last_q;
    res_ready_d = res_ready_q;
    calc_end_d  = calc_end_q;
    snum_d      = snum_q;
    in_we       = 1'b0;
    feed_re     = 1'b0;
    res_we      = 1'b0;
    unique case (state_q)
      BUF_LOAD: begin
        in_we = i_WRITE;
        if (i_DATA_LOADED) begin
          log2_d     = log2_clamp;
          snum_d     = ADDR_W'(CW'(1) << log2_clamp);
          feed_cnt_d = '0;
          res_cnt_d  = '0;
          state_d    = BUF_FEED;
        end
      end
      BUF_FEED: begin
        // Prefetch the next sample whenever the output slot frees up;
        // the RAM output register holds data steady during stalls.
        if (!valid_q || fft_if.fft_ready) begin
          feed_re = feed_more;
          valid_d = feed_more;
          last_d  = feed_more && (feed_cnt_q == n_frame - CW'(1));
          if (feed_more) feed_cnt_d = feed_cnt_q + CW'(1);
        end
        if (valid_q && fft_if.fft_ready && last_q) begin
          valid_d     = 1'b0;
          last_d      = 1'b0;
          res_ready_d = 1'b1;
          state_d     = BUF_COLLECT;
        end
      end
      BUF_COLLECT: begin
        if (fft_if.res_valid) begin
          res_we    = 1'b1;
          res_cnt_d = res_cnt_q + CW'(1);
          if (fft_if.res_last || res_cnt_q == n_frame - CW'(1)) begin
            res_ready_d = 1'b0;
            calc_end_d  = 1'b1;
            state_d     = BUF_DONE;
          end
        end
      end
      BUF_DONE: begin
        in_we = i_WRITE;
        if (i_WRITE) begin
          calc_end_d = 1'b0;
          state_d    = BUF_LOAD;
        end
      end
      default: state_d = BUF_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= BUF_LOAD;
      log2_q      <= 4'(MIN_LOG2);
      feed_cnt_q  <= '0;
      res_cnt_q   <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      res_ready_q <= 1'b0;
      calc_end_q  <= 1'b0;
      snum_q      <= '0;
    end else begin
      state_q     <= state_d;
      log2_q      <= log2_d;
      feed_cnt_q  <= feed_cnt_d;
      res_cnt_q   <= res_cnt_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      res_ready_q <= res_ready_d;
      calc_end_q  <= calc_end_d;
      snum_q      <= snum_d;
    end
  end

  fft_sample_ram #(.WIDTH(16), .AW(ADDR_W)) u_in_ram (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (in_we),
    .waddr (i_SAMPLE_INDEX),
    .wdata (i_SAMPLE),
    .re    (feed_re),
    .raddr (feed_addr),
    .rdata (fft_if.fft_data)
  );

  fft_sample_ram #(.WIDTH(32), .AW(ADDR_W)) u_res_ram (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (res_we),
    .waddr (res_cnt_q[ADDR_W-1:0]),
    .wdata (fft_if.res_data),
    .re    (i_READ),
    .raddr (i_SAMPLE_INDEX),
    .rdata (o_DATA)
  );

  assign fft_if.fft_valid = valid_q;
  assign fft_if.fft_last  = last_q;
  assign fft_if.res_ready = res_ready_q;
  assign o_CALC_END       = calc_end_q;
  assign o_SAMPLES_NUMBER = snum_q;

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Randomized self-checking bench for fft_sample_buffer.
// Reference model: sample/result memory arrays and arithmetic bit reversal.
module tb_fft_sample_buffer;

  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [15:0]   sample;
  logic [AW-1:0] idx;
  logic          wr, rd, loaded;
  logic [3:0]    nlog2;
  logic [31:0]   data;
  logic          calc_end;
  logic [AW-1:0] snum;

  fft_sample_buffer_if bus();

  fft_sample_buffer #(.ADDR_W(AW), .MAX_LOG2(12)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_SAMPLE         (sample),
    .i_SAMPLE_INDEX   (idx),
    .i_WRITE          (wr),
    .i_READ           (rd),
    .i_DATA_LOADED    (loaded),
    .i_N_LOG2         (nlog2),
    .o_DATA           (data),
    .o_CALC_END       (calc_end),
    .o_SAMPLES_NUMBER (snum),
    .fft_if           (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] in_mem  [DEPTH];
  logic [31:0] res_mem [DEPTH];
  int          cur_log2;
  int          cur_n;

  logic [15:0] got_q  [$];
  bit          last_q [$];
  int          stall_err;
  int          first_valid;
  bit          timed_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rev_bits(input int k, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) r = r * 2 + ((k >> b) & 1);
    return r;
  endfunction

  function automatic int clamp_log2(input int l);
    if (l < 1) return 1;
    if (l > 12) return 12;
    return l;
  endfunction

  task automatic write_sample(input int i, input logic [15:0] d);
    idx = AW'(i); sample = d; wr = 1'b1;
    tick();
    wr = 1'b0;
    in_mem[i] = d;
  endtask

  task automatic load(input int l);
    nlog2 = 4'(l); loaded = 1'b1;
    tick();
    loaded = 1'b0;
    cur_log2 = clamp_log2(l);
    cur_n = 1 << cur_log2;
  endtask

  task automatic read_result(input int i, output logic [31:0] d);
    idx = AW'(i); rd = 1'b1;
    tick();
    rd = 1'b0;
    d = data;
  endtask

  // mode 0: ready high, 1: ready toggling, 2: random ready
  task automatic run_stream(input int mode);
    bit held = 0;
    bit done = 0;
    bit r;
    logic [15:0] hd;
    logic hl;
    int bound = 8 * cur_n + 100;
    got_q = {}; last_q = {};
    stall_err = 0; first_valid = -1; timed_out = 0;
    for (int c = 0; c < bound; c++) begin
      case (mode)
        0: r = 1'b1;
        1: r = (c % 2) == 0;
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.fft_ready = r;
      if (bus.fft_valid && first_valid < 0) first_valid = c;
      if (held && (bus.fft_valid !== 1'b1 || bus.fft_data !== hd ||
                   bus.fft_last !== hl)) stall_err++;
      held = 0;
      if (bus.fft_valid) begin
        if (r) begin
          got_q.push_back(bus.fft_data);
          last_q.push_back(bus.fft_last);
          if (bus.fft_last) done = 1;
        end else begin
          held = 1; hd = bus.fft_data; hl = bus.fft_last;
        end
      end
      tick();
      if (done) break;
    end
    bus.fft_ready = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic send_results(input logic [31:0] base, input int count,
                              input int last_at);
    for (int k = 0; k < count; k++) begin
      bus.res_valid = 1'b1;
      bus.res_data  = base + 32'(k);
      bus.res_last  = (k == last_at);
      tick();
    end
    bus.res_valid = 1'b0;
    bus.res_last  = 1'b0;
  endtask

  function automatic int accepted(input int last_at);
    if (last_at >= 0 && last_at < cur_n) return last_at + 1;
    return cur_n;
  endfunction

  task automatic model_results(input logic [31:0] base, input int last_at);
    for (int k = 0; k < accepted(last_at); k++) res_mem[k] = base + 32'(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (data !== 32'h0) begin bad++;
      $display("FAIL reset_data: got %h want 0", data); end
    total++;
    if (calc_end !== 1'b0) begin bad++;
      $display("FAIL reset_calc_end: got %b want 0", calc_end); end
    total++;
    if (snum !== '0) begin bad++;
      $display("FAIL reset_snum: got %0d want 0", snum); end
    total++;
    if ({bus.fft_valid, bus.fft_last, bus.res_ready} !== 3'b000) begin bad++;
      $display("FAIL reset_flags: got %b want 000",
               {bus.fft_valid, bus.fft_last, bus.res_ready}); end
    total++;
    if (bus.fft_data !== 16'h0) begin bad++;
      $display("FAIL reset_fft_data: got %h want 0", bus.fft_data); end
  endtask

  task automatic test_load_n8();
    int errs = 0;
    for (int k = 0; k < 8; k++) write_sample(k, 16'h0010 + 16'(k));
    load(3);
    run_stream(0);
    total++;
    if (timed_out || got_q.size() != 8) begin bad++;
      $display("FAIL n8_count: got %0d want 8 (timeout=%0d)",
               got_q.size(), timed_out); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== in_mem[rev_bits(k, 3)] || last_q[k] !== (k == 7)) begin
        bad++;
        $display("FAIL n8_elem%0d: got %h last %0d want %h last %0d", k,
                 got_q[k], last_q[k], in_mem[rev_bits(k, 3)], k == 7);
      end
    end
    total++;
    if (first_valid !== 1) begin bad++;
      $display("FAIL n8_first_valid: got cycle %0d want 1", first_valid); end
    total++;
    if (snum !== AW'(8)) begin bad++;
      $display("FAIL n8_snum: got %0d want 8", snum); end
    total++;
    if (bus.fft_valid !== 1'b0) begin bad++;
      $display("FAIL n8_valid_after: got %b want 0", bus.fft_valid); end
    if (errs != 0) bad++;
  endtask

  task automatic test_collect_read();
    logic [31:0] d;
    total++;
    if (bus.res_ready !== 1'b1) begin bad++;
      $display("FAIL collect_ready: got %b want 1", bus.res_ready); end
    send_results(32'hA000_0000, 8, 7);
    model_results(32'hA000_0000, 7);
    total++;
    if (calc_end !== 1'b1 || bus.res_ready !== 1'b0) begin bad++;
      $display("FAIL collect_done: got calc_end %b ready %b want 1 0",
               calc_end, bus.res_ready); end
    send_results(32'hC000_0000, 2, -1);
    read_result(3, d);
    total++;
    if (d !== res_mem[3]) begin bad++;
      $display("FAIL read3: got %h want %h", d, res_mem[3]); end
    idx = AW'(5);
    tick();
    total++;
    if (data !== res_mem[3]) begin bad++;
      $display("FAIL read_hold: got %h want %h", data, res_mem[3]); end
    read_result(0, d);
    total++;
    if (d !== res_mem[0]) begin bad++;
      $display("FAIL read0_ignored_extra: got %h want %h", d, res_mem[0]); end
  endtask

  task automatic test_restart_backpressure();
    logic [31:0] d;
    nlog2 = 4'd2; loaded = 1'b1;
    tick();
    loaded = 1'b0;
    total++;
    if (calc_end !== 1'b1) begin bad++;
      $display("FAIL done_ignores_loaded: got %b want 1", calc_end); end
    write_sample(0, 16'h1234);
    total++;
    if (calc_end !== 1'b0) begin bad++;
      $display("FAIL restart_calc_end: got %b want 0", calc_end); end
    load(3);
    run_stream(1);
    total++;
    if (timed_out || got_q.size() != 8 || stall_err != 0) begin bad++;
      $display("FAIL bp_stream: got size %0d stalls %0d want 8 0",
               got_q.size(), stall_err); end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== in_mem[rev_bits(k, 3)] || last_q[k] !== (k == 7)) begin
        bad++;
        $display("FAIL bp_elem%0d: got %h want %h", k, got_q[k],
                 in_mem[rev_bits(k, 3)]);
      end
    end
    send_results(32'hB000_0000, 5, 4);
    model_results(32'hB000_0000, 4);
    total++;
    if (calc_end !== 1'b1 || bus.res_ready !== 1'b0) begin bad++;
      $display("FAIL early_last: got calc_end %b ready %b want 1 0",
               calc_end, bus.res_ready); end
    send_results(32'hE000_0000, 3, -1);
    read_result(5, d);
    total++;
    if (d !== res_mem[5]) begin bad++;
      $display("FAIL early_stale5: got %h want %h", d, res_mem[5]); end
    read_result(4, d);
    total++;
    if (d !== res_mem[4]) begin bad++;
      $display("FAIL early_idx4: got %h want %h", d, res_mem[4]); end
  endtask

  task automatic test_random_frames();
    logic [31:0] d;
    logic [31:0] base;
    int l, errs, ri;
    for (int it = 0; it < 3; it++) begin
      write_sample($urandom_range(0, DEPTH - 1), 16'($urandom));
      l = (it == 0) ? 0 : $urandom_range(1, 6);
      for (int k = 0; k < (1 << clamp_log2(l)); k++)
        write_sample(k, 16'($urandom));
      load(l);
      run_stream(2);
      errs = 0;
      for (int k = 0; k < got_q.size(); k++)
        if (got_q[k] !== in_mem[rev_bits(k, cur_log2)] ||
            last_q[k] !== (k == cur_n - 1)) errs++;
      total++;
      if (timed_out || got_q.size() != cur_n || errs != 0 || stall_err != 0)
      begin bad++;
        $display("FAIL rand%0d_stream: got size %0d errs %0d stalls %0d want %0d 0 0",
                 it, got_q.size(), errs, stall_err, cur_n); end
      total++;
      if (snum !== AW'(cur_n)) begin bad++;
        $display("FAIL rand%0d_snum: got %0d want %0d", it, snum, cur_n); end
      base = $urandom;
      send_results(base, cur_n, -1);
      model_results(base, -1);
      total++;
      if (calc_end !== 1'b1) begin bad++;
        $display("FAIL rand%0d_done: got %b want 1", it, calc_end); end
      ri = $urandom_range(0, cur_n - 1);
      read_result(ri, d);
      total++;
      if (d !== res_mem[ri]) begin bad++;
        $display("FAIL rand%0d_read: got %h want %h", it, d, res_mem[ri]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int errs = 0;
    int first_bad = -1;
    write_sample(0, 16'h0);
    for (int k = 0; k < DEPTH; k++) write_sample(k, 16'($urandom));
    load(15);
    total++;
    if (snum !== '0) begin bad++;
      $display("FAIL ovf_snum: got %0d want 0", snum); end
    run_stream(2);
    for (int k = 0; k < got_q.size(); k++)
      if (got_q[k] !== in_mem[rev_bits(k, 12)] || last_q[k] !== (k == DEPTH - 1))
      begin errs++; if (first_bad < 0) first_bad = k; end
    total++;
    if (timed_out || got_q.size() != DEPTH || errs != 0 || stall_err != 0)
    begin bad++;
      $display("FAIL ovf_stream: got size %0d errs %0d first %0d stalls %0d want 4096 0",
               got_q.size(), errs, first_bad, stall_err); end
    send_results(32'hD000_0000, DEPTH, -1);
    model_results(32'hD000_0000, -1);
    total++;
    if (calc_end !== 1'b1) begin bad++;
      $display("FAIL ovf_done: got %b want 1", calc_end); end
    read_result(DEPTH - 1, d);
    total++;
    if (d !== res_mem[DEPTH-1]) begin bad++;
      $display("FAIL ovf_read: got %h want %h", d, res_mem[DEPTH-1]); end
  endtask

  task automatic test_reset_mid();
    write_sample(0, 16'h5555);
    for (int k = 0; k < 8; k++) write_sample(k, 16'($urandom));
    load(3);
    bus.fft_ready = 1'b1;
    tick(); tick(); tick();
    bus.fft_ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({bus.fft_valid, bus.fft_last, bus.res_ready, calc_end} !== 4'b0000 ||
        bus.fft_data !== 16'h0 || snum !== '0 || data !== 32'h0) begin bad++;
      $display("FAIL midreset_outputs: got v%b l%b r%b c%b d%h n%0d o%h want all 0",
               bus.fft_valid, bus.fft_last, bus.res_ready, calc_end,
               bus.fft_data, snum, data); end
    load(2);
    run_stream(0);
    total++;
    if (timed_out || got_q.size() != 4) begin bad++;
      $display("FAIL midreset_count: got %0d want 4", got_q.size()); end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      total++;
      if (got_q[k] !== in_mem[rev_bits(k, 2)]) begin bad++;
        $display("FAIL midreset_elem%0d: got %h want %h", k, got_q[k],
                 in_mem[rev_bits(k, 2)]); end
    end
    total++;
    if (snum !== AW'(4)) begin bad++;
      $display("FAIL midreset_snum: got %0d want 4", snum); end
  endtask

  initial begin
    rst = 1'b1; sample = '0; idx = '0; wr = 1'b0; rd = 1'b0;
    loaded = 1'b0; nlog2 = '0;
    bus.fft_ready = 1'b0; bus.res_data = '0;
    bus.res_valid = 1'b0; bus.res_last = 1'b0;
    test_reset();
    test_load_n8();
    test_collect_read();
    test_restart_backpressure();
    test_random_frames();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
